dcache_direct_mapped: RTL and testbench

Parametrised direct-mapped data cache between the load/store stage and the burst-capable latency memory model.
- Read misses refill a whole line.
- Writes are write-through, no-write-allocate, with per-byte enables for SB/SH/SW.
- cpu_ready deasserted acts as the CPU freeze.
- Single clock, synchronous active-high reset, one outstanding memory transaction.

---
 rtl/dcache_pkg.sv | 43 ++++
 rtl/dcache_line_ram.sv | 61 ++++++
 rtl/dcache_direct_mapped.sv | 166 ++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data cache.
package dcache_pkg;

    // Controller states: idle/lookup, line refill, and write-through.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_FILL,
        S_WR_REQ,
        S_WR_WAIT
    } state_e;

    // Bits [1:0] of every address select a byte within a 32-bit word.
    localparam int BYTE_OFF_W = 2;

    // Word-offset width within a line.
    function automatic int off_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index width.
    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: whatever address bits remain above the index.
    function automatic int tag_width(input int addr_w, input int num_lines, input int words_per_line);
        return addr_w - BYTE_OFF_W - $clog2(num_lines) - $clog2(words_per_line);
    endfunction

    // Replace only the byte lanes selected by byte_en.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byte_en);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Cache storage: byte-writable data array with asynchronous read, tag array,
// and a valid vector that can be cleared in a single cycle.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 128,
    parameter int WORDS_PER_LINE = 8,
    parameter int TAG_W          = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [idx_width(NUM_LINES)-1:0]    idx,
    input  logic [off_width(WORDS_PER_LINE)-1:0] rd_word,
    output logic [31:0]                        rd_data,
    output logic [TAG_W-1:0]                   rd_tag,
    output logic                               rd_valid,
    input  logic [off_width(WORDS_PER_LINE)-1:0] wr_word,
    input  logic [3:0]                         wr_be,
    input  logic [31:0]                        wr_data,
    input  logic                               tag_we,
    input  logic [TAG_W-1:0]                   wr_tag,
    input  logic                               clr_all
);

    localparam int IDX_W = idx_width(NUM_LINES);
    localparam int OFF_W = off_width(WORDS_PER_LINE);

    logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;

    assign rd_data  = data_mem[{idx, rd_word}];
    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_q[idx];

    // Byte-lane writes into the data array (refill beats and store hits).
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) data_mem[{idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Tag written once per completed refill.
    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[idx] <= wr_tag;
    end

    // Next valid vector: invalidate-all wins, otherwise a completed refill sets its line.
    always_comb begin
        valid_d = valid_q;
        if (clr_all)     valid_d = '0;
        else if (tag_we) valid_d[idx] = 1'b1;
    end

    // Valid register; reset leaves every line invalid.
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with whole-line
// refill on read miss and a single outstanding memory transaction.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 128,
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wr_data,
    input  logic [3:0]        cpu_byte_en,
    input  logic              cpu_inv,
    output logic [31:0]       cpu_rd_data,
    output logic              cpu_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_data_valid,
    input  logic              mem_wr_ack
);

    localparam int OFF_W = off_width(WORDS_PER_LINE);
    localparam int IDX_W = idx_width(NUM_LINES);
    localparam int TAG_W = tag_width(ADDR_W, NUM_LINES, WORDS_PER_LINE);

    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_OFF  = ADDR_W'(WORDS_PER_LINE*4 - 1);

    logic [IDX_W-1:0] addr_idx;
    logic [OFF_W-1:0] addr_off;
    logic [TAG_W-1:0] addr_tag;

    assign addr_off = cpu_addr[BYTE_OFF_W +: OFF_W];
    assign addr_idx = cpu_addr[BYTE_OFF_W + OFF_W +: IDX_W];
    assign addr_tag = cpu_addr[ADDR_W-1 -: TAG_W];

    state_e           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic [31:0]      ram_rd_data;
    logic [TAG_W-1:0] ram_rd_tag;
    logic             ram_rd_valid;
    logic [OFF_W-1:0] ram_wr_word;
    logic [3:0]       ram_be;
    logic [31:0]      ram_wr_data;
    logic             ram_tag_we;
    logic             ram_clr_all;
    logic             hit;

    assign hit = ram_rd_valid && (ram_rd_tag == addr_tag);

    dcache_line_ram #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .idx      (addr_idx),
        .rd_word  (addr_off),
        .rd_data  (ram_rd_data),
        .rd_tag   (ram_rd_tag),
        .rd_valid (ram_rd_valid),
        .wr_word  (ram_wr_word),
        .wr_be    (ram_be),
        .wr_data  (ram_wr_data),
        .tag_we   (ram_tag_we),
        .wr_tag   (addr_tag),
        .clr_all  (ram_clr_all)
    );

    // Next state, beat counter, CPU/memory handshakes and storage write controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpu_ready   = 1'b0;
        cpu_rd_data = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_byte_en = '0;
        ram_wr_word = addr_off;
        ram_be      = '0;
        ram_wr_data = cpu_wr_data;
        ram_tag_we  = 1'b0;
        ram_clr_all = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_wr) begin
                    // Store hits refresh the cached copy now; misses leave the cache alone.
                    if (hit) ram_be = cpu_byte_en;
                    state_d = S_WR_REQ;
                end else if (cpu_rd) begin
                    if (hit) begin
                        cpu_ready   = 1'b1;
                        cpu_rd_data = ram_rd_data;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end else if (cpu_inv) begin
                    ram_clr_all = 1'b1;
                    cpu_ready   = 1'b1;
                end
            end
            S_RD_REQ: begin
                mem_addr = cpu_addr & ~LINE_OFF;
                if (mem_ready) begin
                    mem_rd  = 1'b1;
                    state_d = S_RD_FILL;
                end
            end
            S_RD_FILL: begin
                if (mem_rd_data_valid) begin
                    ram_wr_word = cnt_q;
                    ram_be      = 4'hF;
                    ram_wr_data = mem_rd_data;
                    if (cnt_q == LAST_BEAT) begin
                        ram_tag_we = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + OFF_W'(1);
                    end
                end
            end
            S_WR_REQ: begin
                mem_addr    = cpu_addr;
                mem_wr_data = cpu_wr_data;
                mem_byte_en = cpu_byte_en;
                if (mem_ready) begin
                    mem_wr  = 1'b1;
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (mem_wr_ack) begin
                    cpu_ready = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and beat-counter registers; reset aborts any refill or write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: directed scenarios plus random loads/stores,
// checked against an address-level cache/memory model and a latency memory.
module tb_dcache_direct_mapped;

    localparam int NL  = 4;
    localparam int WPL = 4;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr, cpu_inv;
    logic [31:0] cpu_addr, cpu_wr_data;
    logic [3:0]  cpu_byte_en;
    logic [31:0] cpu_rd_data;
    logic        cpu_ready;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic        mem_ready;
    logic [31:0] mem_rd_data;
    logic        mem_rd_data_valid;
    logic        mem_wr_ack;

    int vecs = 0;
    int errs = 0;

    // Reference: memory contents as the CPU intends them, plus which line each index holds.
    logic [31:0] ref_mem [256];
    bit          m_valid [NL];
    int          m_tag   [NL];

    // Responder memory, changed only by writes the DUT actually issues.
    logic [31:0] resp_mem [256];
    bit rd_pend = 0, ack_pend = 0;
    int rd_dly, rd_beat, rd_base, ack_dly;

    always #5 clk = ~clk;

    dcache_direct_mapped #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_byte_en(cpu_byte_en), .cpu_inv(cpu_inv),
        .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en),
        .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .mem_wr_ack(mem_wr_ack)
    );

    // Latency memory: LAT idle cycles after a request, then a burst or a write ack.
    always @(negedge clk) begin
        mem_rd_data_valid = 1'b0;
        mem_rd_data       = '0;
        mem_wr_ack        = 1'b0;
        if (rd_pend) begin
            if (rd_dly > 0) rd_dly--;
            else begin
                mem_rd_data_valid = 1'b1;
                mem_rd_data       = resp_mem[(rd_base + rd_beat) & 255];
                rd_beat++;
                if (rd_beat == WPL) rd_pend = 0;
            end
        end
        if (ack_pend) begin
            if (ack_dly > 0) ack_dly--;
            else begin
                mem_wr_ack = 1'b1;
                ack_pend   = 0;
            end
        end
        if (mem_rd && !rst) begin
            rd_pend = 1; rd_dly = LAT; rd_beat = 0; rd_base = int'(mem_addr[9:2]);
        end
        if (mem_wr && !rst) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) resp_mem[mem_addr[9:2]][8*b +: 8] = mem_wr_data[8*b +: 8];
            ack_pend = 1; ack_dly = LAT;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        int i;
        i = int'((a >> 4) & 3);
        return m_valid[i] && (m_tag[i] == int'(a >> 6));
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 0);
        chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 0);
        chk({tag, "_ready"}, {31'd0, cpu_ready}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wr_data, 0);
        chk({tag, "_be"}, {28'd0, mem_byte_en}, 0);
        chk({tag, "_rdata"}, cpu_rd_data, 0);
    endtask

    // One load or store: held until cpu_ready; mem_ready low for the first `stall` wait cycles.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input int stall);
        bit exp_hit, done;
        int cyc, nrd, nwr, early, rcyc;
        logic [31:0] rd_a, wr_a, wr_d, rdata, expw;
        logic [3:0]  wr_be;
        exp_hit = m_hit(a);
        done = 0; cyc = 0; nrd = 0; nwr = 0; early = 0; rcyc = -1;
        rd_a = '0; wr_a = '0; wr_d = '0; wr_be = '0; rdata = '0;
        cpu_addr = a; cpu_wr = wr; cpu_rd = !wr; cpu_wr_data = wd; cpu_byte_en = be;
        while (!done && cyc < 200) begin
            mem_ready = (cyc > stall);
            @(negedge clk); #1;
            if ((mem_rd || mem_wr) && !mem_ready) early++;
            if (mem_rd) begin nrd++; rd_a = mem_addr; end
            if (mem_wr) begin nwr++; wr_a = mem_addr; wr_d = mem_wr_data; wr_be = mem_byte_en; end
            if (cpu_ready) begin done = 1; rcyc = cyc; rdata = cpu_rd_data; end
            @(posedge clk); #1;
            cyc++;
        end
        cpu_rd = 0; cpu_wr = 0; mem_ready = 1;
        chk("completed", {31'd0, done}, 1);
        chk("req_while_not_ready", early, 0);
        if (!wr) begin
            chk("rd_mem_rd_count", nrd, exp_hit ? 0 : 1);
            chk("rd_mem_wr_count", nwr, 0);
            if (exp_hit) chk("hit_latency", rcyc, 0);
            else begin
                chk("refill_addr", rd_a, a & ~32'hF);
                chk("miss_latency", rcyc, stall + 2 + LAT + WPL);
                m_valid[(a >> 4) & 3] = 1;
                m_tag[(a >> 4) & 3]   = int'(a >> 6);
            end
            chk("rd_data", rdata, ref_mem[a[9:2]]);
        end else begin
            chk("wr_mem_wr_count", nwr, 1);
            chk("wr_mem_rd_count", nrd, 0);
            chk("wr_addr", wr_a, a);
            chk("wr_data", wr_d, wd);
            chk("wr_be", {28'd0, wr_be}, {28'd0, be});
            chk("wr_latency", rcyc, stall + 2 + LAT);
            expw = ref_mem[a[9:2]];
            for (int b = 0; b < 4; b++) if (be[b]) expw[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a[9:2]] = expw;
        end
    endtask

    task automatic do_inv();
        cpu_inv = 1;
        @(negedge clk); #1;
        chk("inv_ready", {31'd0, cpu_ready}, 1);
        chk("inv_no_mem_rd", {31'd0, mem_rd}, 0);
        @(posedge clk); #1;
        cpu_inv = 0;
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
    endtask

    initial begin
        int beats, k;
        logic [31:0] a;
        rst = 1; cpu_rd = 0; cpu_wr = 0; cpu_inv = 0; cpu_addr = '0;
        cpu_wr_data = '0; cpu_byte_en = '0; mem_ready = 1;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 32'h1300_0000 + i;
            resp_mem[i] = 32'h1300_0000 + i;
        end
        for (int i = 0; i < NL; i++) begin m_valid[i] = 0; m_tag[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk); #1;
        chk_quiet("reset");
        @(posedge clk); #1;

        // Refill, then hit in the same line.
        do_access(0, 32'h40, 0, 0, 0);
        do_access(0, 32'h44, 0, 0, 0);
        // Store hit on one byte lane, then read it back from the cache.
        do_access(1, 32'h44, 32'hAABB_CCDD, 4'b0001, 0);
        do_access(0, 32'h44, 0, 0, 0);
        // Store miss: no allocation, resident line untouched.
        do_access(1, 32'h100, 32'h1234_5678, 4'b1111, 0);
        do_access(0, 32'h44, 0, 0, 0);
        do_access(0, 32'h100, 0, 0, 0);
        // Conflict misses on index 0.
        do_access(0, 32'h40, 0, 0, 0);
        do_access(0, 32'h80, 0, 0, 0);
        do_access(0, 32'h40, 0, 0, 0);
        // mem_ready low for five cycles while the refill request waits.
        do_access(0, 32'hC0, 0, 0, 5);
        do_access(1, 32'hC4, 32'h5566_7788, 4'b1100, 3);
        do_access(0, 32'hC4, 0, 0, 0);

        // Reset in the middle of a refill.
        cpu_addr = 32'h20; cpu_rd = 1; beats = 0; k = 0;
        while (beats < 2 && k < 100) begin
            @(negedge clk); #1;
            if (mem_rd_data_valid) beats++;
            @(posedge clk); #1;
            k++;
        end
        chk("abort_two_beats", beats, 2);
        rst = 1; cpu_rd = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
        @(negedge clk); #1;
        chk_quiet("abort");
        repeat (8) @(posedge clk);
        #1;
        do_access(0, 32'h20, 0, 0, 0);
        do_access(0, 32'h24, 0, 0, 0);

        // Invalidate all.
        do_access(0, 32'h54, 0, 0, 0);
        do_inv();
        do_access(0, 32'h20, 0, 0, 0);
        do_access(0, 32'h54, 0, 0, 0);

        // Random traffic over a small footprint so hits, misses and conflicts all occur.
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 15) == 0) do_inv();
            else if ($urandom_range(0, 2) == 0)
                do_access(1, a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
            else
                do_access(0, a, 0, 0, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
